triumph_decode_pipe: RTL and testbench

//  Parametrised decode stage sitting between the IF and EX stages. Buffers fetched

---
 rtl/triumph_decode_pipe.sv | 173 +++++++++++++++++
 tb/tb_triumph_decode_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/triumph_decode_pipe.sv
// RV32I decode stage: small instruction queue feeding a registered decode slot toward EX.
// The queue head is decoded combinationally and captured into the slot when the slot frees.
module triumph_decode_pipe #(
    parameter  int XLEN     = 32,
    parameter  int IQ_DEPTH = 2,
    localparam int CNT_W    = $clog2(IQ_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             if_valid_i,
    output logic             if_ready_o,
    input  logic [31:0]      if_instr_i,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [2:0]       ex_instr_type_o,
    output logic [6:0]       ex_opcode_o,
    output logic [2:0]       ex_funct3_o,
    output logic [6:0]       ex_funct7_o,
    output logic [4:0]       ex_rs1_addr_o,
    output logic [4:0]       ex_rs2_addr_o,
    output logic [4:0]       ex_rd_addr_o,
    output logic             ex_rd_we_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic             ex_illegal_o,
    output logic [CNT_W-1:0] iq_count_o
);

    localparam int PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);

    localparam logic [2:0] T_R   = 3'd0;
    localparam logic [2:0] T_I   = 3'd1;
    localparam logic [2:0] T_S   = 3'd2;
    localparam logic [2:0] T_B   = 3'd3;
    localparam logic [2:0] T_U   = 3'd4;
    localparam logic [2:0] T_J   = 3'd5;
    localparam logic [2:0] T_ILL = 3'd7;

    logic [31:0]      iq_instr [IQ_DEPTH];
    logic [XLEN-1:0]  iq_pc    [IQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic push;
    logic pop;
    logic slot_free;
    logic empty;

    logic [31:0] head;
    logic [2:0]  dec_type;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_rd_we;
    logic [31:0] imm32;
    logic [XLEN+31:0] imm_wide;

    assign empty      = (count == '0);
    assign if_ready_o = (count < DEPTH_C);
    assign slot_free  = ~ex_valid_o | ex_ready_i;
    assign push       = if_valid_i & if_ready_o & ~flush_i & rst_ni;
    assign pop        = ~empty & slot_free & ~flush_i;
    assign iq_count_o = count;
    assign head       = iq_instr[rd_ptr];
    // replicate bit 31 of the 32-bit immediate up to XLEN without a zero-width replication
    assign imm_wide   = {{XLEN{imm32[31]}}, imm32};

    always_comb begin
        dec_type   = T_ILL;
        dec_funct3 = 3'd0;
        dec_funct7 = 7'd0;
        dec_rs1    = 5'd0;
        dec_rs2    = 5'd0;
        dec_rd     = 5'd0;
        dec_rd_we  = 1'b0;
        imm32      = 32'd0;
        case (head[6:0])
            7'b0110011: dec_type = T_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111: dec_type = T_I;
            7'b0100011: dec_type = T_S;
            7'b1100011: dec_type = T_B;
            7'b0110111, 7'b0010111: dec_type = T_U;
            7'b1101111: dec_type = T_J;
            default:    dec_type = T_ILL;
        endcase
        if (dec_type != T_U && dec_type != T_J)
            dec_funct3 = head[14:12];
        if (dec_type == T_R)
            dec_funct7 = head[31:25];
        if (dec_type == T_R || dec_type == T_I || dec_type == T_S || dec_type == T_B)
            dec_rs1 = head[19:15];
        if (dec_type == T_R || dec_type == T_S || dec_type == T_B)
            dec_rs2 = head[24:20];
        if (dec_type == T_R || dec_type == T_I || dec_type == T_U || dec_type == T_J) begin
            dec_rd    = head[11:7];
            dec_rd_we = (head[11:7] != 5'd0);
        end
        case (dec_type)
            T_I:     imm32 = {{20{head[31]}}, head[31:20]};
            T_S:     imm32 = {{20{head[31]}}, head[31:25], head[11:7]};
            T_B:     imm32 = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
            T_U:     imm32 = {head[31:12], 12'd0};
            T_J:     imm32 = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    // queue storage is not reset; occupancy alone says which entries are meaningful
    always_ff @(posedge clk_i) begin
        if (push) begin
            iq_instr[wr_ptr] <= if_instr_i;
            iq_pc[wr_ptr]    <= if_pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            ex_valid_o      <= 1'b0;
            ex_pc_o         <= '0;
            ex_instr_type_o <= 3'd0;
            ex_opcode_o     <= 7'd0;
            ex_funct3_o     <= 3'd0;
            ex_funct7_o     <= 7'd0;
            ex_rs1_addr_o   <= 5'd0;
            ex_rs2_addr_o   <= 5'd0;
            ex_rd_addr_o    <= 5'd0;
            ex_rd_we_o      <= 1'b0;
            ex_imm_o        <= '0;
            ex_illegal_o    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ex_valid_o <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr          <= rd_ptr + 1'b1;
                ex_valid_o      <= 1'b1;
                ex_pc_o         <= iq_pc[rd_ptr];
                ex_instr_type_o <= dec_type;
                ex_opcode_o     <= head[6:0];
                ex_funct3_o     <= dec_funct3;
                ex_funct7_o     <= dec_funct7;
                ex_rs1_addr_o   <= dec_rs1;
                ex_rs2_addr_o   <= dec_rs2;
                ex_rd_addr_o    <= dec_rd;
                ex_rd_we_o      <= dec_rd_we;
                ex_imm_o        <= imm_wide[XLEN-1:0];
                ex_illegal_o    <= (dec_type == T_ILL);
            end else if (slot_free) begin
                ex_valid_o <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_triumph_decode_pipe.sv
// Directed bench for triumph_decode_pipe: decode vector table plus stall, full and flush sequences.
module tb_triumph_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [2:0]  ex_type;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic [31:0] ex_imm;
    logic        ex_illegal;
    logic [1:0]  iq_count;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  typ;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        we;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs[9];

    triumph_decode_pipe #(.XLEN(32), .IQ_DEPTH(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .if_valid_i(if_valid), .if_ready_o(if_ready), .if_instr_i(if_instr), .if_pc_i(if_pc),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_pc_o(ex_pc),
        .ex_instr_type_o(ex_type), .ex_opcode_o(ex_opcode), .ex_funct3_o(ex_funct3),
        .ex_funct7_o(ex_funct7), .ex_rs1_addr_o(ex_rs1), .ex_rs2_addr_o(ex_rs2),
        .ex_rd_addr_o(ex_rd), .ex_rd_we_o(ex_rd_we), .ex_imm_o(ex_imm),
        .ex_illegal_o(ex_illegal), .iq_count_o(iq_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one clock with a scoreboard: slots leaving toward EX must match push order
    task automatic cycle();
        logic [31:0] exp_pc;
        if (ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", ex_pc, 64'hDEAD);
            end else begin
                exp_pc = exp_q.pop_front();
                chk("sb_order", ex_pc, exp_pc);
            end
        end
        if (if_valid && if_ready)
            exp_q.push_back(if_pc);
        step();
    endtask

    initial begin
        vecs[0] = '{32'h003100B3, 3'd0, 5'd2, 5'd3, 5'd1, 3'd0, 7'h00, 1'b1, 32'h00000000, 1'b0};
        vecs[1] = '{32'hFFF00093, 3'd1, 5'd0, 5'd0, 5'd1, 3'd0, 7'h00, 1'b1, 32'hFFFFFFFF, 1'b0};
        vecs[2] = '{32'hFE000EE3, 3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 1'b0, 32'hFFFFFFFC, 1'b0};
        vecs[3] = '{32'h123450B7, 3'd4, 5'd0, 5'd0, 5'd1, 3'd0, 7'h00, 1'b1, 32'h12345000, 1'b0};
        vecs[4] = '{32'h0000007F, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 1'b0, 32'h00000000, 1'b1};
        vecs[5] = '{32'hFE512C23, 3'd2, 5'd2, 5'd5, 5'd0, 3'd2, 7'h00, 1'b0, 32'hFFFFFFF8, 1'b0};
        vecs[6] = '{32'h008000EF, 3'd5, 5'd0, 5'd0, 5'd1, 3'd0, 7'h00, 1'b1, 32'h00000008, 1'b0};
        vecs[7] = '{32'h00000013, 3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 1'b0, 32'h00000000, 1'b0};
        vecs[8] = '{32'h402081B3, 3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 1'b1, 32'h00000000, 1'b0};

        rst_n = 1'b0; flush = 1'b0; if_valid = 1'b1; if_instr = 32'h00000013;
        if_pc = 32'h0; ex_ready = 1'b1;

        // reset held two edges while IF keeps offering
        step();
        step();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_count", iq_count, 0);
        chk("rst_pc", ex_pc, 0);
        chk("rst_type", ex_type, 0);
        chk("rst_opcode", ex_opcode, 0);
        chk("rst_imm", ex_imm, 0);
        chk("rst_rd_we", ex_rd_we, 0);
        chk("rst_illegal", ex_illegal, 0);
        chk("rst_regs", {ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7}, 0);
        rst_n = 1'b1; if_valid = 1'b0;
        chk("rst_if_ready", if_ready, 1);

        // decode table: one isolated push per vector
        for (int i = 0; i < 9; i++) begin
            if_valid = 1'b1; if_instr = vecs[i].instr; if_pc = 32'h100 + 32'(4 * i);
            step();
            if_valid = 1'b0;
            if (i == 0) chk("lat_not_yet_valid", ex_valid, 0);
            step();
            chk("tbl_valid", ex_valid, 1);
            chk("tbl_pc", ex_pc, 32'h100 + 32'(4 * i));
            chk("tbl_type", ex_type, vecs[i].typ);
            chk("tbl_opcode", ex_opcode, vecs[i].instr[6:0]);
            chk("tbl_rs1", ex_rs1, vecs[i].rs1);
            chk("tbl_rs2", ex_rs2, vecs[i].rs2);
            chk("tbl_rd", ex_rd, vecs[i].rd);
            chk("tbl_funct3", ex_funct3, vecs[i].f3);
            chk("tbl_funct7", ex_funct7, vecs[i].f7);
            chk("tbl_rd_we", ex_rd_we, vecs[i].we);
            chk("tbl_imm", ex_imm, vecs[i].imm);
            chk("tbl_illegal", ex_illegal, vecs[i].ill);
        end
        step();
        chk("drain_valid", ex_valid, 0);

        // backpressure: three pushes against a stalled EX
        exp_q.delete();
        ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if_valid = 1'b1; if_instr = 32'h00000013; if_pc = 32'h200 + 32'(4 * k);
            cycle();
        end
        if_valid = 1'b0;
        chk("bp_count", iq_count, 2);
        chk("bp_if_ready", if_ready, 0);
        chk("bp_hold_pc", ex_pc, 32'h200);
        cycle();
        cycle();
        chk("bp_hold_pc2", ex_pc, 32'h200);
        chk("bp_hold_valid", ex_valid, 1);
        ex_ready = 1'b1;
        cycle();
        chk("bp_out_b", ex_pc, 32'h204);
        cycle();
        chk("bp_out_c", ex_pc, 32'h208);
        cycle();
        chk("bp_empty", ex_valid, 0);

        // full queue with EX ready: no push that edge, then steady push+pop
        ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if_valid = 1'b1; if_pc = 32'h300 + 32'(4 * k);
            cycle();
        end
        ex_ready = 1'b1; if_pc = 32'h400;
        chk("full_if_ready", if_ready, 0);
        cycle();
        chk("full_count_after", iq_count, 1);
        for (int k = 0; k < 10; k++) begin
            if_pc = 32'h400 + 32'(4 * k);
            cycle();
            chk("steady_count", iq_count, 1);
        end
        if_valid = 1'b0;
        begin
            int guard = 0;
            while (ex_valid && guard < 20) begin
                cycle();
                guard++;
            end
            chk("drain_timeout", {63'd0, ex_valid}, 0);
        end
        chk("sb_leftover", exp_q.size(), 0);

        // flush with a full queue and a valid slot
        ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if_valid = 1'b1; if_pc = 32'h500 + 32'(4 * k);
            step();
        end
        chk("fl_pre_count", iq_count, 2);
        chk("fl_pre_valid", ex_valid, 1);
        flush = 1'b1; if_valid = 1'b1; if_pc = 32'h600; ex_ready = 1'b1;
        step();
        flush = 1'b0; if_valid = 1'b0;
        chk("fl_valid", ex_valid, 0);
        chk("fl_count", iq_count, 0);
        chk("fl_if_ready", if_ready, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fl_no_ghost", {ex_valid, iq_count}, 0);
        end

        // illegal opcode after flush still waits for the handshake
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h0000007F; if_pc = 32'h700;
        step();
        if_valid = 1'b0;
        step();
        chk("ill_valid", ex_valid, 1);
        chk("ill_type", ex_type, 7);
        chk("ill_flag", ex_illegal, 1);
        chk("ill_pc", ex_pc, 32'h700);
        step();
        chk("ill_held", ex_valid, 1);
        ex_ready = 1'b1;
        step();
        chk("ill_consumed", ex_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
